// File: rtl/run_ctrl_pkg.sv
// Shared types and widths for the run controller and its stream index counters.
package run_ctrl_pkg;

    localparam int IMEM_ADDR_W = 5;
    localparam int REG_ADDR_W  = 5;
    localparam int DATA_W      = 8;
    localparam int INST_W      = 32;
    localparam int CNT_W       = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CLEAR = 3'd2,
        ST_RUN   = 3'd3,
        ST_DUMP  = 3'd4
    } run_state_t;

endpackage

// File: rtl/stream_index_counter.sv
// Handshake-driven stream index with a last-beat flag; wraps to zero after the last beat.
module stream_index_counter
    import run_ctrl_pkg::*;
#(
    parameter int W    = IMEM_ADDR_W,
    parameter int LAST = 31
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         advance,
    output logic [W-1:0] index,
    output logic         last
);

    localparam logic [W-1:0] LAST_IDX = W'(LAST);
    localparam logic [W-1:0] ONE      = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] index_r;

    // Index register: synchronous clear has priority over a handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index_r <= {W{1'b0}};
        end else if (clear) begin
            index_r <= {W{1'b0}};
        end else if (advance) begin
            index_r <= index_r + ONE;
        end else begin
            index_r <= index_r;
        end
    end

    assign index = index_r;
    assign last  = (index_r == LAST_IDX);

endmodule

// File: rtl/run_controller.sv
// Sequences one program run: load imem, flush, run with timeout, then dump the register file.
module run_controller
    import run_ctrl_pkg::*;
#(
    parameter int IMEM_DEPTH     = 32,
    parameter int NUM_REGS       = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic [INST_W-1:0]      load_data,
    output logic                   imem_we,
    output logic [IMEM_ADDR_W-1:0] imem_waddr,
    output logic [INST_W-1:0]      imem_wdata,
    output logic                   core_clear,
    output logic                   core_run,
    input  logic                   core_done,
    output logic [REG_ADDR_W-1:0]  rf_raddr,
    input  logic [DATA_W-1:0]      rf_rdata,
    output logic                   dump_valid,
    input  logic                   dump_ready,
    output logic [REG_ADDR_W-1:0]  dump_addr,
    output logic [DATA_W-1:0]      dump_data,
    output logic                   busy,
    output logic                   timeout,
    output logic [CNT_W-1:0]       cycle_count
);

    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    run_state_t             state_r, state_next_s;
    logic [CNT_W-1:0]       cycle_count_r, cycle_count_next_s, cycle_inc_s;
    logic                   timeout_r, timeout_next_s;

    logic                   start_accept_s;
    logic                   load_fire_s, load_last_s;
    logic                   dump_fire_s, dump_last_s;
    logic [IMEM_ADDR_W-1:0] load_index_s;
    logic [REG_ADDR_W-1:0]  dump_index_s;
    logic                   dump_clear_s;

    assign start_accept_s = (state_r == ST_IDLE) & start;
    assign load_fire_s    = (state_r == ST_LOAD) & load_valid;
    assign dump_fire_s    = (state_r == ST_DUMP) & dump_ready;
    assign dump_clear_s   = (state_r == ST_RUN);
    assign cycle_inc_s    = cycle_count_r + CNT_ONE;

    stream_index_counter #(
        .W    (IMEM_ADDR_W),
        .LAST (IMEM_DEPTH - 1)
    ) u_load_idx (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (start_accept_s),
        .advance (load_fire_s),
        .index   (load_index_s),
        .last    (load_last_s)
    );

    stream_index_counter #(
        .W    (REG_ADDR_W),
        .LAST (NUM_REGS - 1)
    ) u_dump_idx (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (dump_clear_s),
        .advance (dump_fire_s),
        .index   (dump_index_s),
        .last    (dump_last_s)
    );

    // State, run-cycle counter and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            cycle_count_r <= {CNT_W{1'b0}};
            timeout_r     <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            cycle_count_r <= cycle_count_next_s;
            timeout_r     <= timeout_next_s;
        end
    end

    // Next-state logic; core_done takes priority over the timeout in the same RUN cycle.
    always_comb begin
        state_next_s       = state_r;
        cycle_count_next_s = cycle_count_r;
        timeout_next_s     = timeout_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s       = ST_LOAD;
                    cycle_count_next_s = {CNT_W{1'b0}};
                    timeout_next_s     = 1'b0;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (load_fire_s && load_last_s) begin
                    state_next_s = ST_CLEAR;
                end else begin
                    state_next_s = ST_LOAD;
                end
            end
            ST_CLEAR: begin
                state_next_s = ST_RUN;
            end
            ST_RUN: begin
                cycle_count_next_s = cycle_inc_s;
                if (core_done) begin
                    state_next_s = ST_DUMP;
                end else if (cycle_inc_s == TIMEOUT_VAL) begin
                    state_next_s   = ST_DUMP;
                    timeout_next_s = 1'b1;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DUMP: begin
                if (dump_fire_s && dump_last_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DUMP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    assign busy        = (state_r != ST_IDLE);
    assign load_ready  = (state_r == ST_LOAD);
    assign imem_we     = load_fire_s;
    assign imem_waddr  = load_index_s;
    assign imem_wdata  = load_data;
    assign core_clear  = (state_r == ST_CLEAR);
    assign core_run    = (state_r == ST_RUN);
    assign dump_valid  = (state_r == ST_DUMP);
    assign dump_addr   = dump_index_s;
    assign rf_raddr    = dump_index_s;
    assign dump_data   = rf_rdata;
    assign timeout     = timeout_r;
    assign cycle_count = cycle_count_r;

endmodule

// File: tb/tb_run_controller.sv
// Directed self-checking bench for run_controller with a short timeout.
module tb_run_controller;
    import run_ctrl_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   start;
    logic                   load_valid;
    logic                   load_ready;
    logic [INST_W-1:0]      load_data;
    logic                   imem_we;
    logic [IMEM_ADDR_W-1:0] imem_waddr;
    logic [INST_W-1:0]      imem_wdata;
    logic                   core_clear;
    logic                   core_run;
    logic                   core_done;
    logic [REG_ADDR_W-1:0]  rf_raddr;
    logic [DATA_W-1:0]      rf_rdata;
    logic                   dump_valid;
    logic                   dump_ready;
    logic [REG_ADDR_W-1:0]  dump_addr;
    logic [DATA_W-1:0]      dump_data;
    logic                   busy;
    logic                   timeout;
    logic [CNT_W-1:0]       cycle_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Register file stand-in: reg 7 holds 0xA5, the rest 0x40 + index.
    assign rf_rdata = (rf_raddr == 5'd7) ? 8'hA5 : (8'h40 + {3'b000, rf_raddr});

    run_controller #(
        .IMEM_DEPTH     (32),
        .NUM_REGS       (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_data   (load_data),
        .imem_we     (imem_we),
        .imem_waddr  (imem_waddr),
        .imem_wdata  (imem_wdata),
        .core_clear  (core_clear),
        .core_run    (core_run),
        .core_done   (core_done),
        .rf_raddr    (rf_raddr),
        .rf_rdata    (rf_rdata),
        .dump_valid  (dump_valid),
        .dump_ready  (dump_ready),
        .dump_addr   (dump_addr),
        .dump_data   (dump_data),
        .busy        (busy),
        .timeout     (timeout),
        .cycle_count (cycle_count)
    );

    function automatic logic [7:0] exp_reg(input int idx);
        logic [7:0] v;
        v = 8'h40 + 8'(idx);
        if (idx == 7) v = 8'hA5;
        return v;
    endfunction

    function automatic logic [31:0] exp_word(input bit bp, input int idx);
        logic [31:0] w;
        w = 32'h0000_0013;
        if (bp) w = w | (32'(idx) << 20);
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},        32'(busy),        32'd0);
        chk({tag, "_load_ready"},  32'(load_ready),  32'd0);
        chk({tag, "_imem_we"},     32'(imem_we),     32'd0);
        chk({tag, "_core_clear"},  32'(core_clear),  32'd0);
        chk({tag, "_core_run"},    32'(core_run),    32'd0);
        chk({tag, "_dump_valid"},  32'(dump_valid),  32'd0);
        chk({tag, "_imem_waddr"},  32'(imem_waddr),  32'd0);
        chk({tag, "_rf_raddr"},    32'(rf_raddr),    32'd0);
        chk({tag, "_dump_addr"},   32'(dump_addr),   32'd0);
        chk({tag, "_dump_data"},   32'(dump_data),   32'(exp_reg(0)));
        chk({tag, "_cycle_count"}, 32'(cycle_count), 32'd0);
        chk({tag, "_timeout"},     32'(timeout),     32'd0);
    endtask

    // Called just after a rising edge in IDLE; returns just after the edge that enters RUN.
    task automatic do_load(input bit bp, input int stray_at, input bit done_noise);
        int idx;
        int n;
        start = 1'b1;
        #2;
        chk("busy_before_start_edge", 32'(busy), 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        idx = 0;
        n = 0;
        while (idx < 32 && n < 200) begin
            load_valid = bp ? ((n % 2) == 0) : 1'b1;
            load_data  = exp_word(bp, idx);
            start      = (n == stray_at);
            core_done  = done_noise;
            @(negedge clk);
            if (n == 0) begin
                chk("entry_busy",        32'(busy),        32'd1);
                chk("entry_cycle_count", 32'(cycle_count), 32'd0);
                chk("entry_timeout",     32'(timeout),     32'd0);
            end
            chk("load_ready", 32'(load_ready), 32'd1);
            chk("imem_we",    32'(imem_we),    32'(load_valid));
            chk("core_run_in_load", 32'(core_run), 32'd0);
            if (load_valid) begin
                chk("imem_waddr", 32'(imem_waddr), 32'(idx));
                chk("imem_wdata", imem_wdata, exp_word(bp, idx));
                idx++;
            end
            n++;
            @(posedge clk); #1;
        end
        load_valid = 1'b0;
        start = 1'b0;
        chk("load_cycles", 32'(n), bp ? 32'd63 : 32'd32);
        @(negedge clk);
        chk("clear_pulse",      32'(core_clear), 32'd1);
        chk("clear_core_run",   32'(core_run),   32'd0);
        chk("clear_load_ready", 32'(load_ready), 32'd0);
        @(posedge clk); #1;
    endtask

    // Returns at the falling edge of the first DUMP cycle.
    task automatic do_run(input int done_at, input int exp_n, input bit exp_to);
        int n;
        bit going;
        n = 0;
        going = 1'b1;
        while (going && n < 100) begin
            core_done = (n + 1 == done_at);
            @(negedge clk);
            if (core_run) begin
                n++;
                chk("core_clear_in_run", 32'(core_clear), 32'd0);
                @(posedge clk); #1;
            end else begin
                going = 1'b0;
            end
        end
        core_done = 1'b0;
        chk("run_cycles",   32'(n),           32'(exp_n));
        chk("cycle_count",  32'(cycle_count), 32'(exp_n));
        chk("timeout_flag", 32'(timeout),     32'(exp_to));
        chk("dump_entered", 32'(dump_valid),  32'd1);
    endtask

    // Starts and ends at a falling edge; stalls dump_ready at stall_idx for stall_len cycles.
    task automatic do_dump(input int stall_idx, input int stall_len);
        int idx;
        int stalls;
        int n;
        idx = 0;
        stalls = 0;
        n = 0;
        while (idx < 32 && n < 200) begin
            dump_ready = !(idx == stall_idx && stalls < stall_len);
            chk("dump_valid", 32'(dump_valid), 32'd1);
            chk("dump_addr",  32'(dump_addr),  32'(idx));
            chk("rf_raddr",   32'(rf_raddr),   32'(idx));
            chk("dump_data",  32'(dump_data),  32'(exp_reg(idx)));
            chk("dump_core_run", 32'(core_run), 32'd0);
            if (dump_ready) idx++;
            else stalls++;
            n++;
            @(posedge clk);
            @(negedge clk);
        end
        dump_ready = 1'b1;
        chk("dump_cycles",     32'(n),          32'(32 + stall_len));
        chk("busy_after_dump", 32'(busy),       32'd0);
        chk("valid_after_dump", 32'(dump_valid), 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        load_valid = 1'b1;
        load_data  = 32'h0000_0013;
        core_done  = 1'b0;
        dump_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        load_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Nominal run with a stray start during LOAD
        do_load(1'b0, 5, 1'b0);
        do_run(10, 10, 1'b0);
        do_dump(-1, 0);
        chk("nominal_idle_timeout", 32'(timeout), 32'd0);
        chk("nominal_idle_count",   32'(cycle_count), 32'd10);
        @(posedge clk); #1;

        // Load backpressure, done/timeout tie, dump backpressure at reg 7
        do_load(1'b1, -1, 1'b0);
        do_run(16, 16, 1'b0);
        do_dump(7, 5);
        @(posedge clk); #1;

        // Timeout run; core_done noise outside RUN must be ignored
        do_load(1'b0, -1, 1'b1);
        do_run(0, 16, 1'b1);
        do_dump(-1, 0);
        core_done = 1'b1;
        repeat (3) @(negedge clk);
        core_done = 1'b0;
        chk("hold_timeout", 32'(timeout),     32'd1);
        chk("hold_count",   32'(cycle_count), 32'd16);
        chk("hold_idle",    32'(busy),        32'd0);
        @(posedge clk); #1;

        // Reset asserted mid-RUN
        do_load(1'b0, -1, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("pre_reset_run", 32'(core_run), 32'd1);
        load_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrun_reset");
        @(negedge clk);
        load_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/run_controller.md
# run_controller

Sequencer that owns one complete program run of the 5-stage core. It loads the 32-entry instruction memory from a host stream, flushes and releases the core, and counts run cycles against a timeout. When the core signals `done` or times out, it halts the core and streams the 32 architectural registers back to the host. It sits between the host/testbench side and the core's instruction-memory write port, run-enable and register-file debug read port.

## Interface
- `IMEM_DEPTH`, 32: instruction words loaded per run; the index is 5 bits.
- `NUM_REGS`, 32: registers dumped per run.
- `TIMEOUT_CYCLES`, 1024: maximum number of RUN cycles; valid range 1..65535.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: run request; sampled only in IDLE.
- `load_valid` in 1 / `load_ready` out 1 / `load_data` in 32: instruction stream handshake.
- `imem_we` out 1, `imem_waddr` out 5, `imem_wdata` out 32: instruction memory write port.
- `core_clear` out 1: one-cycle flush pulse to the core (pc and pipeline registers).
- `core_run` out 1: core clock-enable; the core holds its state while this is low.
- `core_done` in 1: the core's `done` output.
- `rf_raddr` out 5 / `rf_rdata` in 8: register-file debug read port; the read is combinational.
- `dump_valid` out 1 / `dump_ready` in 1 / `dump_addr` out 5 / `dump_data` out 8: register dump stream.
- `busy` out 1: high in every state except IDLE.
- `timeout` out 1: sticky flag; high if the last run hit `TIMEOUT_CYCLES`.
- `cycle_count` out 16: number of RUN cycles in the last run.

## Operation
States are IDLE, LOAD, CLEAR, RUN and DUMP.
- **IDLE**
  - Exit: `start`=1 → LOAD.
  - Entry actions: load index = 0, `cycle_count` = 0, `timeout` = 0.
- **LOAD**
  - `load_ready`=1.
  - `imem_we` = `load_valid`, combinational. `imem_waddr` = load index. `imem_wdata` = `load_data`.
  - On each handshake the index increments.
  - Exit: handshake at index `IMEM_DEPTH`-1 → CLEAR.
  - `load_valid` low for any number of cycles is legal; no write occurs in those cycles.
- **CLEAR**
  - Exactly one cycle, with `core_clear`=1 and `core_run`=0.
  - Exit: → RUN.
- **RUN**
  - `core_run`=1.
  - `cycle_count` increments every RUN cycle.
  - Exit: `core_done`=1 → DUMP, with the dump index at 0.
  - Exit: `cycle_count` reaching `TIMEOUT_CYCLES` → DUMP, and `timeout` is set.
  - If both exits apply in the same cycle, `core_done` wins and `timeout` stays 0.
- **DUMP**
  - `core_run`=0.
  - `dump_valid`=1. `dump_addr` = `rf_raddr` = dump index. `dump_data` = `rf_rdata`.
  - The data is stable while the core is halted. The index advances on `dump_valid`&`dump_ready`.
  - Exit: handshake at index `NUM_REGS`-1 → IDLE.
- `start` outside IDLE is ignored; it is neither queued nor allowed to restart the run.
- `core_done` outside RUN is ignored.
- `cycle_count` and `timeout` hold their values through DUMP and IDLE until the next accepted `start`.

## Timing
- Reset values: state IDLE, all indices 0, `cycle_count`=0, `timeout`=0.
- All outputs are low at reset (`busy`, `load_ready`, `imem_we`, `core_clear`, `core_run`, `dump_valid`, `imem_waddr`/`rf_raddr`/`dump_addr`=0). `dump_data` follows `rf_rdata`.
- `start` sampled high at edge N: `load_ready`=1 and `busy`=1 from cycle N+1.
- Best-case LOAD lasts 32 cycles. CLEAR is 1 cycle. The first `core_run` cycle immediately follows CLEAR.
- `core_done` high at edge M: `core_run`=0 from cycle M+1, and the core executes no further cycle.
- `cycle_count` equals the number of cycles in which `core_run` was 1. It never exceeds `TIMEOUT_CYCLES`.
- DUMP with `dump_ready` held high takes 32 cycles. `busy` falls the cycle after the last dump handshake.
- Stream stability rule: `dump_valid` and `dump_addr` do not change while `dump_valid`=1 and `dump_ready`=0.
- Reset asserted mid-run (any state): immediate return to reset values; `core_run` drops asynchronously.

## Structure
- Shared package `run_ctrl_pkg`:
  - state enum `run_state_t`
  - `IMEM_ADDR_W`=5, `REG_ADDR_W`=5, `DATA_W`=8, `INST_W`=32, `CNT_W`=16
- One sub-module, `stream_index_counter`: a 5-bit index with handshake-increment and last-beat flag. It is instantiated once for LOAD and once for DUMP.
- FSM, cycle counter and flags live in `run_controller`.

## Test plan
- **Nominal run**
  - Stimulus: `start`, then 32 words 0x0000_0013 streamed with `load_valid` always high.
  - Checks:
    - `imem_we` high on 32 consecutive cycles, `imem_waddr` 0..31.
    - One `core_clear` pulse.
    - `core_done` forced high after 10 RUN cycles gives `cycle_count`=10 and `timeout`=0.
    - 32 dump beats with addr 0..31.
- **Load backpressure**
  - Stimulus: `load_valid` toggles 1/0.
  - Checks: LOAD lasts 63 cycles; there is no write in the valid-low cycles; addresses stay contiguous.
- **Timeout**
  - Stimulus: `TIMEOUT_CYCLES`=16, `core_done` never asserted.
  - Checks: `core_run` high exactly 16 cycles; `timeout`=1; `cycle_count`=16; the dump still completes.
- **Done/timeout tie**
  - Stimulus: `core_done` asserted in the cycle `cycle_count` reaches 16.
  - Checks: `timeout`=0.
- **Dump backpressure**
  - Stimulus: `dump_ready` low for 5 cycles at index 7, with `rf_rdata`=0xA5 for reg 7.
  - Checks: `dump_addr`=7 and `dump_data`=0xA5 held for those 5 cycles; reg 8 follows.
- **Reset and stray start**
  - Stimulus: `rst_n` pulled low mid-RUN.
  - Checks: all outputs at reset values within the same cycle.
  - Stimulus: `start` pulsed during LOAD.
  - Checks: no effect on the load index.
